// File: rtl/assoc_tag_comparator.sv
// Two-stage set-associative tag comparator: sliced per-way compare, then priority encode.
// Optional multi-hit detection is compiled in with ASSOC_TAG_COMPARATOR_MULTIHIT_EN.
module assoc_tag_comparator #(
  parameter int BW     = 20,
  parameter int N_WAYS = 4,
  localparam int BW_WAY = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [BW-1:0]        tag_i,
  input  logic [N_WAYS*BW-1:0] way_tags_i,
  input  logic [N_WAYS-1:0]    way_valid_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 hit_o,
  output logic [BW_WAY-1:0]    hit_way_o,
  output logic [N_WAYS-1:0]    match_vec_o
`ifdef ASSOC_TAG_COMPARATOR_MULTIHIT_EN
  ,
  output logic                 multi_hit_o,
  output logic                 err_o
`endif
);

  localparam int NS = (BW + 3) / 4;

  function automatic logic [BW_WAY-1:0] f_prio(input logic [N_WAYS-1:0] v);
    f_prio = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (v[i]) f_prio = i[BW_WAY-1:0];
    end
  endfunction

  logic [N_WAYS-1:0] w_match_p0;
  logic              w_s2_load;
  logic              w_s1_adv;

  logic              r_vld_p1;
  logic [N_WAYS-1:0] r_match_p1;
  logic              r_vld_p2;
  logic              r_hit_p2;
  logic [BW_WAY-1:0] r_way_p2;
  logic [N_WAYS-1:0] r_match_p2;

  // Stage 0: per-way compare in 4-bit slices, last slice may be narrower
  for (genvar k = 0; k < N_WAYS; k++) begin : g_way
    logic [NS-1:0] w_slice_eq;
    for (genvar s = 0; s < NS; s++) begin : g_slice
      localparam int LO = 4 * s;
      localparam int HI = (LO + 3 < BW) ? LO + 3 : BW - 1;
      assign w_slice_eq[s] = (tag_i[HI:LO] == way_tags_i[k*BW+HI : k*BW+LO]);
    end
    assign w_match_p0[k] = way_valid_i[k] & (&w_slice_eq);
  end

  assign w_s2_load   = !r_vld_p2 || rsp_ready_i;
  assign w_s1_adv    = !r_vld_p1 || w_s2_load;
  assign req_ready_o = w_s1_adv;

  // Stage 1: registered match vector
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)      r_vld_p1 <= 1'b0;
    else if (w_s1_adv) r_vld_p1 <= req_valid_i;
  end

  always_ff @(posedge clock_i) begin
    if (w_s1_adv && req_valid_i) r_match_p1 <= w_match_p0;
  end

  // Stage 2: priority-encoded result; data only loads when a real result moves in
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_vld_p2   <= 1'b0;
      r_hit_p2   <= 1'b0;
      r_way_p2   <= '0;
      r_match_p2 <= '0;
    end else if (w_s2_load) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_hit_p2   <= |r_match_p1;
        r_way_p2   <= f_prio(r_match_p1);
        r_match_p2 <= r_match_p1;
      end
    end
  end

  assign rsp_valid_o = r_vld_p2;
  assign hit_o       = r_hit_p2;
  assign hit_way_o   = r_way_p2;
  assign match_vec_o = r_match_p2;

`ifdef ASSOC_TAG_COMPARATOR_MULTIHIT_EN
  function automatic logic f_multi(input logic [N_WAYS-1:0] v);
    f_multi = ((v & (v - 1'b1)) != '0);
  endfunction

  logic r_multi_p2;
  logic r_err;

  // err is sticky once a multi-hit result has been handed to the consumer
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_multi_p2 <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_s2_load && r_vld_p1) r_multi_p2 <= f_multi(r_match_p1);
      if (r_vld_p2 && rsp_ready_i && r_multi_p2) r_err <= 1'b1;
    end
  end

  assign multi_hit_o = r_multi_p2;
  assign err_o       = r_err;
`endif

endmodule

// File: tb/tb_assoc_tag_comparator.sv
// Scoreboard bench for assoc_tag_comparator: default 20x4 instance plus a 7x1 instance.
module tb_assoc_tag_comparator;
  localparam int BW = 20;
  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           req_valid, req_ready, rsp_valid, rsp_ready, hit;
  logic [BW-1:0]  tag;
  logic [NW*BW-1:0] ways;
  logic [NW-1:0]  wv, vec;
  logic [1:0]     hway;
`ifdef ASSOC_TAG_COMPARATOR_MULTIHIT_EN
  logic           multi, err;
  logic           d2_multi, d2_err;
`endif

  logic       d2_req_valid, d2_req_ready, d2_rsp_valid, d2_hit, d2_hway;
  logic [6:0] d2_tag, d2_way;
  logic       d2_wv, d2_vec;

  assoc_tag_comparator #(.BW(BW), .N_WAYS(NW)) dut (
    .clock_i(clk), .reset_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .tag_i(tag), .way_tags_i(ways), .way_valid_i(wv), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .hit_o(hit), .hit_way_o(hway), .match_vec_o(vec)
`ifdef ASSOC_TAG_COMPARATOR_MULTIHIT_EN
    , .multi_hit_o(multi), .err_o(err)
`endif
  );

  assoc_tag_comparator #(.BW(7), .N_WAYS(1)) dut2 (
    .clock_i(clk), .reset_i(rst_n), .req_valid_i(d2_req_valid), .req_ready_o(d2_req_ready),
    .tag_i(d2_tag), .way_tags_i(d2_way), .way_valid_i(d2_wv), .rsp_valid_o(d2_rsp_valid),
    .rsp_ready_i(1'b1), .hit_o(d2_hit), .hit_way_o(d2_hway), .match_vec_o(d2_vec)
`ifdef ASSOC_TAG_COMPARATOR_MULTIHIT_EN
    , .multi_hit_o(d2_multi), .err_o(d2_err)
`endif
  );

  typedef struct packed {
    logic [NW-1:0] vec;
    logic          hit;
    logic [1:0]    way;
    logic          multi;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int n_rsp  = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [BW-1:0] t, input logic [NW*BW-1:0] w,
                                 input logic [NW-1:0] v);
    exp_t m;
    m = '0;
    for (int k = 0; k < NW; k++)
      if (v[k] && (w[k*BW +: BW] == t)) m.vec[k] = 1'b1;
    m.hit = |m.vec;
    for (int k = NW - 1; k >= 0; k--)
      if (m.vec[k]) m.way = k[1:0];
    m.multi = ($countones(m.vec) > 1);
    return m;
  endfunction

  function automatic logic [NW*BW-1:0] mk_ways(input logic [BW-1:0] t0, t1, t2, t3);
    return {t3, t2, t1, t0};
  endfunction

  // Monitor: pops the scoreboard on every result transfer, checks stall stability
  logic          prev_stall = 1'b0;
  logic          pv_hit;
  logic [1:0]    pv_way;
  logic [NW-1:0] pv_vec;
  logic          exp_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      exp_err    = 1'b0;
    end else begin
`ifdef ASSOC_TAG_COMPARATOR_MULTIHIT_EN
      chk("err_sticky", err, exp_err);
`endif
      if (prev_stall) begin
        chk("stall_valid", rsp_valid, 1);
        chk("stall_hit", hit, pv_hit);
        chk("stall_way", hway, pv_way);
        chk("stall_vec", vec, pv_vec);
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rsp_vec", vec, e.vec);
          chk("rsp_hit", hit, e.hit);
          chk("rsp_way", hway, e.way);
`ifdef ASSOC_TAG_COMPARATOR_MULTIHIT_EN
          chk("rsp_multi", multi, e.multi);
          if (e.multi) exp_err = 1'b1;
`endif
          n_rsp++;
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      pv_hit = hit;
      pv_way = hway;
      pv_vec = vec;
    end
  end

  task automatic drive_one(input logic [BW-1:0] t, input logic [NW*BW-1:0] w,
                           input logic [NW-1:0] v);
    bit acc = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; tag = t; ways = w; wv = v;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready) begin
        q.push_back(model(t, w, v));
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic latency_check(input string nm);
    @(posedge clk); #1;
    req_valid = 1'b1; tag = 20'hABCDE;
    ways = mk_ways(20'h11111, 20'h22222, 20'hABCDE, 20'h33333); wv = 4'b1111;
    @(negedge clk);
    chk({nm, "_ready"}, req_ready, 1);
    if (req_ready) q.push_back(model(tag, ways, wv));
    chk({nm, "_c0"}, rsp_valid, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_c1"}, rsp_valid, 0);
    @(negedge clk);
    chk({nm, "_c2"}, rsp_valid, 1);
    wait_empty();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, base;
    bit saw_nr;
    logic [NW-1:0] sv;
    logic [BW-1:0] st;

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    tag = '0; ways = '0; wv = '0;
    d2_req_valid = 1'b0; d2_tag = '0; d2_way = '0; d2_wv = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_way", hway, 0);
    chk("rst_vec", vec, 0);
    chk("rst_req_ready", req_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_ready", req_ready, 1);

    latency_check("lat_first");

    drive_one(20'hABCDE, mk_ways(20'h11111, 20'h22222, 20'hABCDE, 20'h33333), 4'b1011);
    drive_one(20'h5A5A5, mk_ways(20'h00000, 20'h5A5A5, 20'h12345, 20'h5A5A5), 4'b1111);
    drive_one(20'h5A5A5, mk_ways(20'h5A5A5, 20'h5A5A5, 20'h5A5A5, 20'h5A5A5), 4'b0000);
    drive_one(20'hFFFFF, mk_ways(20'h7FFFF, 20'hFFFFE, 20'hEFFFF, 20'hFFFFF), 4'b0111);
    drive_one(20'h00001, mk_ways(20'h00001, 20'h00001, 20'h00001, 20'h00001), 4'b1111);
    wait_empty();

    // back-to-back stream with a stall window
    idx = 0; saw_nr = 1'b0; base = n_rsp;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      rsp_ready = !(c >= 3 && c <= 6);
      if (idx < 8) begin
        sv = 4'(idx + 1);
        st = 20'h10000 + 20'(idx);
        req_valid = 1'b1; tag = st; wv = 4'b1111;
        ways = mk_ways(sv[0] ? st : ~st, sv[1] ? st : ~st, sv[2] ? st : ~st, sv[3] ? st : ~st);
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (!req_ready) saw_nr = 1'b1;
      if (req_valid && req_ready) begin
        q.push_back(model(tag, ways, wv));
        idx++;
      end
    end
    chk("stream_backpressure", saw_nr, 1);
    chk("stream_accepted", idx, 8);
    chk("stream_results", n_rsp - base, 8);
    chk("stream_queue_empty", q.size(), 0);

    // reset while a result is stalled
    @(posedge clk); #1 rsp_ready = 1'b0;
    drive_one(20'h0F0F0, mk_ways(20'h0F0F0, 20'h0F0F0, 20'h1, 20'h2), 4'b1111);
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    chk("stall_reached", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_hit", hit, 0);
    chk("midrst_way", hway, 0);
    chk("midrst_vec", vec, 0);
    chk("midrst_req_ready", req_ready, 1);
`ifdef ASSOC_TAG_COMPARATOR_MULTIHIT_EN
    chk("midrst_multi", multi, 0);
    chk("midrst_err", err, 0);
`endif
    q.delete();
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    latency_check("lat_after_rst");

    // narrow single-way instance
    @(posedge clk); #1;
    d2_req_valid = 1'b1; d2_tag = 7'h55; d2_way = 7'h15; d2_wv = 1'b1;
    @(posedge clk); #1;
    d2_way = 7'h55;
    @(posedge clk); #1;
    d2_req_valid = 1'b0;
    @(negedge clk);
    chk("d2_miss_valid", d2_rsp_valid, 1);
    chk("d2_miss_hit", d2_hit, 0);
    chk("d2_miss_vec", d2_vec, 0);
    @(negedge clk);
    chk("d2_hit_valid", d2_rsp_valid, 1);
    chk("d2_hit_hit", d2_hit, 1);
    chk("d2_hit_way", d2_hway, 0);
    chk("d2_hit_vec", d2_vec, 1);
    @(negedge clk);
    chk("d2_idle", d2_rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/assoc_tag_comparator.md
ASSOC_TAG_COMPARATOR -- requirements
Module: assoc_tag_comparator

Interface
REQ-001 SHALL have parameter BW, default 20, meaning tag width in bits, legal range 1..32.
REQ-002 SHALL have parameter N_WAYS, default 4, meaning number of ways compared in parallel, legal range 1..16.
REQ-003 SHALL have localparam BW_WAY = max(1, ceil(log2(N_WAYS))), meaning the width of the way index.
REQ-004 clock_i  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  in  1  asynchronous, active-low reset.
REQ-006 req_valid_i  in  1  the request on tag_i, way_tags_i and way_valid_i is valid.
REQ-007 req_ready_o  out  1  the block accepts the request in this cycle.
REQ-008 tag_i  in  BW  lookup tag.
REQ-009 way_tags_i  in  N_WAYS*BW  stored tags; way k occupies bits [(k+1)*BW-1 : k*BW].
REQ-010 way_valid_i  in  N_WAYS  per-way line valid bits.
REQ-011 rsp_valid_o  out  1  the result is valid.
REQ-012 rsp_ready_i  in  1  the consumer accepts the result.
REQ-013 hit_o  out  1  at least one valid way matched.
REQ-014 hit_way_o  out  BW_WAY  lowest-numbered matching way; 0 when there is no hit.
REQ-015 match_vec_o  out  N_WAYS  raw per-way (valid AND tag-equal) vector.
REQ-016 multi_hit_o, err_o  out  1 each  present only under REQ-030.

Function
REQ-017 A request SHALL transfer when req_valid_i && req_ready_o; a result SHALL transfer when rsp_valid_o && rsp_ready_i.
REQ-018 Stage 1 SHALL compare each way in 4-bit slices (final slice 1-3 bits when BW mod 4 != 0), AND-reduce the slices, qualify with way_valid_i[k], and register the match vector plus a stage-1 valid bit.
REQ-019 Stage 2 SHALL priority-encode the registered match vector and register hit_o, hit_way_o, match_vec_o and rsp_valid_o.
REQ-020 Latency SHALL be 2 cycles from request transfer to rsp_valid_o with no backpressure; throughput SHALL be 1 request per cycle.
REQ-021 Stage 2 SHALL load when !rsp_valid_o || rsp_ready_i; stage 1 SHALL advance when !s1_valid || stage 2 loads; req_ready_o = !s1_valid || stage-2 load, a combinational path from rsp_ready_i that is permitted.
REQ-022 While rsp_valid_o=1 && rsp_ready_i=0, all outputs SHALL hold stable and no request or result SHALL be lost or duplicated.
REQ-023 A request with way_valid_i all-zero SHALL yield hit_o=0, hit_way_o=0, match_vec_o=0.
REQ-024 For N_WAYS=1, hit_way_o SHALL be the constant 0.
REQ-025 Stage-1 and stage-2 data registers SHALL NOT load when their stage is not advancing; stall bubbles SHALL be removed, so a result drains into an empty stage 2 even while no new request arrives.

Reset
REQ-026 Asserting reset_i SHALL immediately clear s1_valid, rsp_valid_o, hit_o, hit_way_o, match_vec_o, multi_hit_o and err_o to 0, including mid-stall; in-flight results SHALL be discarded.
REQ-027 req_ready_o SHALL be 1 during and after reset.
REQ-028 The first request accepted after reset deassertion SHALL produce rsp_valid_o exactly 2 cycles later.

Configuration
REQ-029 Macro ASSOC_TAG_COMPARATOR_MULTIHIT_EN SHALL gate multi-hit detection.
REQ-030 With the macro defined: multi_hit_o=1 alongside a result whose match_vec_o has more than one bit set; err_o is sticky, set when a multi-hit result transfers, and cleared only by reset.
REQ-031 Without the macro: multi_hit_o and err_o ports are absent and no detection logic exists; all other behaviour is identical.

Verification (BW=20, N_WAYS=4)
REQ-032 tag_i=0xABCDE, way 2 tag 0xABCDE, way_valid=4'b1111, rsp_ready=1 -> 2 cycles later: hit=1, hit_way=2, match_vec=4'b0100.
REQ-033 Same request with way_valid=4'b1011 -> hit=0, hit_way=0, match_vec=0.
REQ-034 Ways 1 and 3 both equal tag_i, all valid -> hit_way=1, match_vec=4'b1010; with macro, multi_hit=1 and err=1 held until reset.
REQ-035 Back-to-back stream of 8 requests, rsp_ready held 0 for cycles 3-6 -> req_ready=0 once both stages are full, 8 results in order with none dropped or repeated, outputs stable while stalled.
REQ-036 reset_i asserted while rsp_valid=1 and stalled -> all outputs 0 immediately; next request responds after 2 cycles.
REQ-037 BW=7, N_WAYS=1: tag_i differs from way 0 only in bit 6 -> hit=0; equal -> hit=1, hit_way=0.
